// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter
//
// Shares one fully pipelined FP32 multiplier (fixed latency, no backpressure)
// between NUM_REQ requesters. Requests are granted round-robin, the winning
// operands are registered onto the multiplier port, and a tag pipeline of
// {valid, id} travels alongside the multiplier so each product is routed back
// to the requester that issued it.
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   enable_i                issue enable; low blocks new grants
//   req_valid_i             per-requester request valid
//   req_a_i, req_b_i        packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_ready_o             grant, one-hot or zero
//   mul_valid_o/a_o/b_o     registered issue to the multiplier
//   mul_valid_i/product_i   multiplier result
//   rsp_valid_o             registered one-hot response strobe
//   rsp_product_o, rsp_id_o shared response product and requester ID
//   busy_o                  any operation issued or still in flight
//   err_o                   sticky tag/valid mismatch
module fp_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 3,
  parameter int DATA_W      = 32,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      mul_valid_o,
  output logic [DATA_W-1:0]         mul_a_o,
  output logic [DATA_W-1:0]         mul_b_o,
  input  logic                      mul_valid_i,
  input  logic [DATA_W-1:0]         mul_product_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_product_o,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic                      busy_o,
  output logic                      err_o
);

  logic [ID_W-1:0]        ptr;
  logic [ID_W-1:0]        grant_id;
  logic                   grant_found;
  logic                   handshake;
  logic [ID_W-1:0]        issue_id;
  logic [MUL_LATENCY-1:0] tag_valid;
  logic [ID_W-1:0]        tag_id [MUL_LATENCY];
  logic                   tag_out_valid;
  logic [ID_W-1:0]        tag_out_id;
  logic [NUM_REQ-1:0]     rsp_onehot;

  // Round-robin search: walk the offsets from the highest down to zero so the
  // requester closest to the pointer (offset 0 first) is the last one written
  // and therefore wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid_i[ID_W'(idx)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // Grant is only presented while issue is enabled.
  always_comb begin
    req_ready_o = '0;
    if (enable_i && grant_found) req_ready_o[grant_id] = 1'b1;
  end

  assign handshake = |(req_valid_i & req_ready_o);

  // Pointer moves just past the last requester served; holds otherwise.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr <= '0;
    end else if (handshake) begin
      ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Issue stage: operands hold their last values between issues.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mul_valid_o <= 1'b0;
      mul_a_o     <= '0;
      mul_b_o     <= '0;
      issue_id    <= '0;
    end else begin
      mul_valid_o <= handshake;
      if (handshake) begin
        mul_a_o  <= req_a_i[int'(grant_id)*DATA_W +: DATA_W];
        mul_b_o  <= req_b_i[int'(grant_id)*DATA_W +: DATA_W];
        issue_id <= grant_id;
      end
    end
  end

  // Tag pipeline: the entry loaded while mul_valid_o is high reaches the last
  // stage in exactly the cycle the multiplier presents the matching product.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tag_valid <= '0;
      for (int s = 0; s < MUL_LATENCY; s++) tag_id[s] <= '0;
    end else begin
      tag_valid[0] <= mul_valid_o;
      tag_id[0]    <= issue_id;
      for (int s = 1; s < MUL_LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
    end
  end

  assign tag_out_valid = tag_valid[MUL_LATENCY-1];
  assign tag_out_id    = tag_id[MUL_LATENCY-1];

  always_comb begin
    rsp_onehot             = '0;
    rsp_onehot[tag_out_id] = 1'b1;
  end

  // Response stage and sticky error. A mismatched cycle produces no response
  // because the response needs both the tag and the multiplier valid.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rsp_valid_o   <= '0;
      rsp_product_o <= '0;
      rsp_id_o      <= '0;
      err_o         <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      if (tag_out_valid && mul_valid_i) begin
        rsp_valid_o   <= rsp_onehot;
        rsp_product_o <= mul_product_i;
        rsp_id_o      <= tag_out_id;
      end
      if (tag_out_valid != mul_valid_i) err_o <= 1'b1;
    end
  end

  assign busy_o = mul_valid_o | (|tag_valid);

endmodule
